// File: rtl/turfbus_resp.sv
// TURFbus response packetiser: on a TURF request, streams header, source words
// (LSB first), a status byte and an XOR checksum as one contiguous byte run.
module turfbus_resp #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        treq_n_i,
  input  logic [31:0] src_dat_i,
  input  logic        src_valid_i,
  input  logic        src_last_i,
  output logic        src_ready_o,
  output logic [7:0]  td_o,
  output logic        sreq_n_o,
  output logic        busy_o,
  output logic        req_drop_o
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SH_W   = 24;
  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_STAT,
    S_CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] td_d;
  logic              sreq_n_d;
  logic              busy_d;
  logic              drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              last_q, last_d;
  logic              treq_q;
  logic              armed_q;
  logic              req_det;
  logic              word_slot;
  logic              below_max;
  logic [BYTE_W-1:0] status;

  // armed_q blocks a request until treq_n_i has actually been sampled high after reset
  assign req_det   = armed_q & treq_q & ~treq_n_i;
  assign below_max = (cnt_q < MAX_CNT);
  assign word_slot = (state_q == S_HDR) || ((state_q == S_DATA) && (bidx_q == 2'd3));
  assign src_ready_o = word_slot & src_valid_i & ~last_q & below_max;
  assign status    = {5'b0, ~last_q & below_max, ~last_q & ~below_max, last_q};

  // Next-state and next-output logic; outputs reflect the state being entered
  always_comb begin
    state_d  = state_q;
    td_d     = '0;
    sreq_n_d = 1'b1;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_det) begin
          state_d  = S_HDR;
          td_d     = HDR_BYTE;
          sreq_n_d = 1'b0;
          csum_d   = HDR_BYTE;
          cnt_d    = '0;
          last_d   = 1'b0;
        end
      end
      S_HDR, S_DATA: begin
        sreq_n_d = 1'b0;
        if (word_slot) begin
          if (src_ready_o) begin
            state_d = S_DATA;
            bidx_d  = 2'd0;
            td_d    = src_dat_i[7:0];
            sh_d    = src_dat_i[31:8];
            cnt_d   = cnt_q + CNT_W'(1);
            last_d  = last_q | src_last_i;
          end else begin
            state_d = S_STAT;
            td_d    = status;
          end
        end else begin
          td_d   = sh_q[7:0];
          sh_d   = {8'h00, sh_q[SH_W-1:8]};
          bidx_d = bidx_q + 2'd1;
        end
        csum_d = csum_q ^ td_d;
      end
      S_STAT: begin
        state_d  = S_CSUM;
        td_d     = csum_q;
        sreq_n_d = 1'b0;
      end
      S_CSUM: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    drop_d = req_det && (state_q != S_IDLE);
  end

  // State and registered outputs; reset aborts any packet immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      td_o       <= '0;
      sreq_n_o   <= 1'b1;
      busy_o     <= 1'b0;
      req_drop_o <= 1'b0;
      cnt_q      <= '0;
      csum_q     <= '0;
      bidx_q     <= '0;
      sh_q       <= '0;
      last_q     <= 1'b0;
      treq_q     <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      td_o       <= td_d;
      sreq_n_o   <= sreq_n_d;
      busy_o     <= busy_d;
      req_drop_o <= drop_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      bidx_q     <= bidx_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
      treq_q     <= treq_n_i;
      armed_q    <= armed_q | treq_n_i;
    end
  end

endmodule

// File: tb/tb_turfbus_resp.sv
// Directed bench for turfbus_resp: expected bytes and packet lengths are queued
// as stimulus is issued and popped as the DUT drives the bus.
module tb_turfbus_resp;

  localparam int unsigned MAXW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        treq_n = 1'b0;
  logic [31:0] src_dat = '0;
  logic        src_valid = 1'b0;
  logic        src_last = 1'b0;
  logic        src_ready;
  logic [7:0]  td;
  logic        sreq_n;
  logic        busy;
  logic        req_drop;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  int          len_q[$];
  logic [31:0] sd_q[$];
  logic        sl_q[$];
  int   run_len = 0;
  int   ready_cycles = 0;
  int   drop_cycles = 0;
  logic drop_prev = 1'b0;
  logic acc_pend = 1'b0;

  always #5 clk = ~clk;

  turfbus_resp #(.MAX_WORDS(MAXW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .treq_n_i    (treq_n),
    .src_dat_i   (src_dat),
    .src_valid_i (src_valid),
    .src_last_i  (src_last),
    .src_ready_o (src_ready),
    .td_o        (td),
    .sreq_n_o    (sreq_n),
    .busy_o      (busy),
    .req_drop_o  (req_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: scoreboard pop, packet length, ready and drop pulse tracking
  always @(negedge clk) begin
    if (!sreq_n) begin
      run_len++;
      chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("td_byte", 32'(td), 32'(exp_q.pop_front()));
    end else begin
      chk("idle_td", 32'(td), 32'd0);
      if (run_len > 0) begin
        chk("pkt_len_queued", 32'(len_q.size() != 0), 32'd1);
        if (len_q.size() != 0) chk("pkt_len", 32'(run_len), 32'(len_q.pop_front()));
        run_len = 0;
      end
    end
    if (src_ready) ready_cycles++;
    acc_pend = src_valid && src_ready;
    if (req_drop) begin
      drop_cycles++;
      chk("drop_width", 32'(drop_prev), 32'd0);
    end
    drop_prev = req_drop;
  end

  // Source model: presents queue head, pops on acceptance
  always @(posedge clk) begin
    #1;
    if (acc_pend && sd_q.size() != 0) begin
      void'(sd_q.pop_front());
      void'(sl_q.pop_front());
    end
    src_valid = (sd_q.size() != 0);
    src_dat   = src_valid ? sd_q[0] : 32'h0;
    src_last  = src_valid ? sl_q[0] : 1'b0;
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    sd_q.push_back(d);
    sl_q.push_back(l);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input int n, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [7:0] st);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'hA5;
    push_byte(8'hA5);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int b = 0; b < 4; b++) begin
        push_byte(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    push_byte(st);
    cs = cs ^ st;
    push_byte(cs);
    len_q.push_back(3 + 4 * n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic request();
    @(negedge clk);
    treq_n = 1'b0;
    @(negedge clk);
    treq_n = 1'b1;
    #2;
    chk("req_start_sreq", 32'(sreq_n), 32'd0);
    chk("req_start_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && !busy && sreq_n;
    end
    chk("wait_idle", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with treq_n held low through reset release
    tick(3);
    chk("rst_td", 32'(td), 32'h00);
    chk("rst_sreq_n", 32'(sreq_n), 32'd1);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_drop", 32'(req_drop), 32'd0);
    rst = 1'b0;
    tick(5);
    chk("held_low_busy", 32'(busy), 32'd0);
    chk("held_low_sreq_n", 32'(sreq_n), 32'd1);
    treq_n = 1'b1;
    tick(2);

    // Empty source
    push_byte(8'hA5); push_byte(8'h04); push_byte(8'hA1);
    len_q.push_back(3);
    request();
    wait_idle();

    // Single word with last
    push_word(32'h11223344, 1'b1);
    tick(2);
    ready_cycles = 0;
    push_byte(8'hA5); push_byte(8'h44); push_byte(8'h33); push_byte(8'h22);
    push_byte(8'h11); push_byte(8'h01); push_byte(8'hE0);
    len_q.push_back(7);
    request();
    wait_idle();
    chk("single_ready_cycles", 32'(ready_cycles), 32'd1);
    chk("single_src_drained", 32'(sd_q.size()), 32'd0);

    // MAX_WORDS limit then underflow
    for (int i = 0; i < 5; i++) push_word(32'h10203040 + 32'(i) * 32'h01010101, 1'b0);
    tick(2);
    push_pkt(2, 32'h10203040, 32'h11213141, 8'h02);
    request();
    wait_idle();
    push_pkt(2, 32'h12223242, 32'h13233343, 8'h02);
    request();
    wait_idle();
    push_pkt(1, 32'h14243444, 32'h0, 8'h04);
    request();
    wait_idle();
    chk("max_src_drained", 32'(sd_q.size()), 32'd0);

    // Request while in DATA is dropped, packet unchanged
    push_word(32'hDEADBEEF, 1'b0);
    push_word(32'h01234567, 1'b1);
    tick(2);
    push_pkt(2, 32'hDEADBEEF, 32'h01234567, 8'h01);
    request();
    @(negedge clk);
    @(negedge clk);
    treq_n = 1'b0;
    @(negedge clk);
    treq_n = 1'b1;
    wait_idle();
    chk("busy_drop_count", 32'(drop_cycles), 32'd1);

    // Request landing on the CSUM -> IDLE edge is dropped
    push_byte(8'hA5); push_byte(8'h04); push_byte(8'hA1);
    len_q.push_back(3);
    request();
    @(negedge clk);
    @(negedge clk);
    treq_n = 1'b0;
    @(negedge clk);
    treq_n = 1'b1;
    wait_idle();
    tick(3);
    chk("csum_drop_count", 32'(drop_cycles), 32'd2);
    chk("csum_drop_no_pkt", 32'(busy), 32'd0);

    // Reset during DATA byte 2, then resume with the next word
    push_word(32'hCAFEF00D, 1'b0);
    push_word(32'h0BADBEEF, 1'b0);
    tick(2);
    push_byte(8'hA5); push_byte(8'h0D); push_byte(8'hF0); push_byte(8'hFE);
    len_q.push_back(4);
    request();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        #2;
        seen = (exp_q.size() == 0);
      end
      chk("mid_reached_byte2", 32'(seen), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_sreq_n", 32'(sreq_n), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_td", 32'(td), 32'h00);
    chk("mid_rst_src_ready", 32'(src_ready), 32'd0);
    tick(2);
    rst = 1'b0;
    push_pkt(1, 32'h0BADBEEF, 32'h0, 8'h04);
    request();
    wait_idle();
    chk("mid_src_drained", 32'(sd_q.size()), 32'd0);

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_len_empty", 32'(len_q.size()), 32'd0);
    chk("final_drop_count", 32'(drop_cycles), 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
